// File: rtl/alu_rr_sequencer.sv
// Fetch/execute control sequencer for register-register ALU instructions (T0..T6).
// Optional single-step gating of every T-state transition: define ALU_SEQ_STEP_EN.
module alu_rr_sequencer #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_WIDTH  = 5,
  parameter int REG_SEL_WIDTH = 4,
  parameter int NUM_REGS      = 16,
  parameter logic [OPCODE_WIDTH-1:0] MUL_OPCODE = 5'h0F,
  parameter logic [OPCODE_WIDTH-1:0] DIV_OPCODE = 5'h10
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    start,
  input  logic                    mem_ready,
`ifdef ALU_SEQ_STEP_EN
  input  logic                    step,
`endif
  input  logic [DATA_WIDTH-1:0]   ir_data,
  output logic                    pc_out,
  output logic                    mar_in,
  output logic                    inc_pc,
  output logic                    z_in,
  output logic                    zlow_out,
  output logic                    zhigh_out,
  output logic                    pc_in,
  output logic                    read,
  output logic                    mdr_in,
  output logic                    mdr_out,
  output logic                    ir_in,
  output logic                    y_in,
  output logic                    lo_in,
  output logic                    hi_in,
  output logic [NUM_REGS-1:0]     reg_out_sel,
  output logic [NUM_REGS-1:0]     reg_in_sel,
  output logic [OPCODE_WIDTH-1:0] alu_op,
  output logic                    busy,
  output logic                    done
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] T0   = 3'd1;
  localparam logic [2:0] T1   = 3'd2;
  localparam logic [2:0] T2   = 3'd3;
  localparam logic [2:0] T3   = 3'd4;
  localparam logic [2:0] T4   = 3'd5;
  localparam logic [2:0] T5   = 3'd6;
  localparam logic [2:0] T6   = 3'd7;

  localparam int RA_MSB  = DATA_WIDTH - OPCODE_WIDTH - 1;
  localparam int RB_MSB  = RA_MSB - REG_SEL_WIDTH;
  localparam int RC_MSB  = RB_MSB - REG_SEL_WIDTH;
  localparam int LOW_MSB = RC_MSB - REG_SEL_WIDTH;

  function automatic logic [NUM_REGS-1:0] onehot(input logic [REG_SEL_WIDTH-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  logic [2:0]               state_q, state_d;
  logic                     adv;
  logic [OPCODE_WIDTH-1:0]  op_d, op_q;
  logic [REG_SEL_WIDTH-1:0] ra_d, rb_d, rc_d, ra_q, rb_q, rc_q;
  logic                     muldiv_d, muldiv_q;
  logic                     unused_ir;

  assign op_d      = ir_data[DATA_WIDTH-1 -: OPCODE_WIDTH];
  assign ra_d      = ir_data[RA_MSB -: REG_SEL_WIDTH];
  assign rb_d      = ir_data[RB_MSB -: REG_SEL_WIDTH];
  assign rc_d      = ir_data[RC_MSB -: REG_SEL_WIDTH];
  assign muldiv_d  = (op_d == MUL_OPCODE) || (op_d == DIV_OPCODE);
  assign unused_ir = ^ir_data[LOW_MSB:0];

`ifdef ALU_SEQ_STEP_EN
  assign adv = step;
`else
  assign adv = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = T0;
      T0:      if (adv) state_d = T1;
      T1:      if (adv && mem_ready) state_d = T2;
      T2:      if (adv) state_d = T3;
      T3:      if (adv) state_d = T4;
      T4:      if (adv) state_d = T5;
      T5:      if (adv) state_d = muldiv_q ? T6 : IDLE;
      T6:      if (adv) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Decode snapshot: taken on the edge leaving T3, used by T4..T6 only
  always_ff @(posedge clk) begin
    if (state_q == T3 && adv) begin
      op_q     <= op_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      rc_q     <= rc_d;
      muldiv_q <= muldiv_d;
    end
  end

  always_comb begin
    pc_out      = 1'b0;
    mar_in      = 1'b0;
    inc_pc      = 1'b0;
    z_in        = 1'b0;
    zlow_out    = 1'b0;
    zhigh_out   = 1'b0;
    pc_in       = 1'b0;
    read        = 1'b0;
    mdr_in      = 1'b0;
    mdr_out     = 1'b0;
    ir_in       = 1'b0;
    y_in        = 1'b0;
    lo_in       = 1'b0;
    hi_in       = 1'b0;
    reg_out_sel = '0;
    reg_in_sel  = '0;
    alu_op      = '0;
    done        = 1'b0;
    busy        = (state_q != IDLE);
    case (state_q)
      T0: begin
        pc_out = 1'b1;
        mar_in = 1'b1;
        inc_pc = 1'b1;
        z_in   = 1'b1;
      end
      T1: begin
        zlow_out = 1'b1;
        pc_in    = 1'b1;
        read     = 1'b1;
        mdr_in   = 1'b1;
      end
      T2: begin
        mdr_out = 1'b1;
        ir_in   = 1'b1;
      end
      T3: begin
        y_in        = 1'b1;
        reg_out_sel = muldiv_d ? onehot(ra_d) : onehot(rb_d);
      end
      T4: begin
        z_in        = 1'b1;
        alu_op      = op_q;
        reg_out_sel = muldiv_q ? onehot(rb_q) : onehot(rc_q);
      end
      T5: begin
        zlow_out = 1'b1;
        if (muldiv_q) begin
          lo_in = 1'b1;
        end else begin
          reg_in_sel = onehot(ra_q);
          done       = adv;
        end
      end
      T6: begin
        zhigh_out = 1'b1;
        hi_in     = 1'b1;
        done      = adv;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Directed bench for alu_rr_sequencer: normal, mul, memory wait, reset mid-op, busy-ignore.
module tb_alu_rr_sequencer;

  logic        clk = 1'b0;
  logic        clr, start, mem_ready;
  logic [31:0] ir_data;
  logic        pc_out, mar_in, inc_pc, z_in, zlow_out, zhigh_out, pc_in, read;
  logic        mdr_in, mdr_out, ir_in, y_in, lo_in, hi_in, busy, done;
  logic [15:0] reg_out_sel, reg_in_sel;
  logic [4:0]  alu_op;
  logic [13:0] strb;
`ifdef ALU_SEQ_STEP_EN
  logic        step;
`endif

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  localparam logic [13:0] S_PC_OUT = 14'h2000, S_MAR_IN = 14'h1000, S_INC_PC = 14'h0800,
                          S_Z_IN = 14'h0400, S_ZLOW = 14'h0200, S_ZHIGH = 14'h0100,
                          S_PC_IN = 14'h0080, S_READ = 14'h0040, S_MDR_IN = 14'h0020,
                          S_MDR_OUT = 14'h0010, S_IR_IN = 14'h0008, S_Y_IN = 14'h0004,
                          S_LO_IN = 14'h0002, S_HI_IN = 14'h0001;
  localparam logic [13:0] E_T0 = S_PC_OUT | S_MAR_IN | S_INC_PC | S_Z_IN;
  localparam logic [13:0] E_T1 = S_ZLOW | S_PC_IN | S_READ | S_MDR_IN;
  localparam logic [13:0] E_T2 = S_MDR_OUT | S_IR_IN;

  alu_rr_sequencer dut (
    .clk(clk), .clr(clr), .start(start), .mem_ready(mem_ready),
`ifdef ALU_SEQ_STEP_EN
    .step(step),
`endif
    .ir_data(ir_data),
    .pc_out(pc_out), .mar_in(mar_in), .inc_pc(inc_pc), .z_in(z_in),
    .zlow_out(zlow_out), .zhigh_out(zhigh_out), .pc_in(pc_in), .read(read),
    .mdr_in(mdr_in), .mdr_out(mdr_out), .ir_in(ir_in), .y_in(y_in),
    .lo_in(lo_in), .hi_in(hi_in), .reg_out_sel(reg_out_sel), .reg_in_sel(reg_in_sel),
    .alu_op(alu_op), .busy(busy), .done(done)
  );

  assign strb = {pc_out, mar_in, inc_pc, z_in, zlow_out, zhigh_out, pc_in, read,
                 mdr_in, mdr_out, ir_in, y_in, lo_in, hi_in};

  always #5 clk = ~clk;

  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [13:0] es, input logic [15:0] eo,
                           input logic [15:0] ei, input logic [4:0] eop,
                           input logic eb, input logic ed);
    chk({tag, "_strb"}, {18'd0, strb}, {18'd0, es});
    chk({tag, "_rout"}, {16'd0, reg_out_sel}, {16'd0, eo});
    chk({tag, "_rin"},  {16'd0, reg_in_sel},  {16'd0, ei});
    chk({tag, "_op"},   {27'd0, alu_op},      {27'd0, eop});
    chk({tag, "_busy"}, {31'd0, busy},        {31'd0, eb});
    chk({tag, "_done"}, {31'd0, done},        {31'd0, ed});
  endtask

  // Drives one instruction from the current IDLE cycle and checks every T-state.
  task automatic run_instr(input string tag, input logic [31:0] ir, input int waits,
                           input bit md, input logic [15:0] e3, input logic [15:0] e4,
                           input logic [15:0] ein, input logic [4:0] eop, input bit noise);
    int d0;
    d0        = done_cnt;
    ir_data   = ir;
    mem_ready = (waits == 0);
    start     = 1'b1;
    tick();
    start = 1'b0;
    chk_state({tag, "_t0"}, E_T0, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0);
    tick();
    for (int i = 0; i <= waits; i++) begin
      chk_state({tag, "_t1"}, E_T1, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0);
      mem_ready = (i == waits);
      tick();
    end
    mem_ready = 1'b1;
    chk_state({tag, "_t2"}, E_T2, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0);
    start = noise;
    tick();
    start = 1'b0;
    chk_state({tag, "_t3"}, S_Y_IN, e3, 16'h0, 5'h0, 1'b1, 1'b0);
    tick();
    chk_state({tag, "_t4"}, S_Z_IN, e4, 16'h0, eop, 1'b1, 1'b0);
    tick();
    if (md) begin
      chk_state({tag, "_t5"}, S_ZLOW | S_LO_IN, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0);
      start = noise;
      tick();
      start = 1'b0;
      chk_state({tag, "_t6"}, S_ZHIGH | S_HI_IN, 16'h0, 16'h0, 5'h0, 1'b1, 1'b1);
    end else begin
      chk_state({tag, "_t5"}, S_ZLOW, 16'h0, ein, 5'h0, 1'b1, 1'b1);
      start = noise;
      tick();
      start = 1'b0;
    end
    if (md) tick();
    chk_state({tag, "_idle"}, 14'h0, 16'h0, 16'h0, 5'h0, 1'b0, 1'b0);
    chk({tag, "_ndone"}, done_cnt - d0, 32'd1);
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; mem_ready = 1'b1; ir_data = 32'h0;
`ifdef ALU_SEQ_STEP_EN
    step = 1'b1;
`endif
    tick();
    tick();
    clr = 1'b0;
    chk_state("reset", 14'h0, 16'h0, 16'h0, 5'h0, 1'b0, 1'b0);

    // Start held low: must stay idle
    tick();
    chk("idle_hold_busy", {31'd0, busy}, 32'd0);

    run_instr("seq", 32'h489A8000, 0, 1'b0, 16'h0008, 16'h0020, 16'h0002, 5'h09, 1'b0);
    run_instr("mul", 32'h79200000, 0, 1'b1, 16'h0004, 16'h0010, 16'h0000, 5'h0F, 1'b0);
    // div: op 0x10, Ra=7, Rb=9, Rc=1
    run_instr("div", 32'h83C88000, 0, 1'b1, 16'h0080, 16'h0200, 16'h0000, 5'h10, 1'b0);
    run_instr("wait", 32'h489A8000, 3, 1'b0, 16'h0008, 16'h0020, 16'h0002, 5'h09, 1'b0);
    // Ra=15, Rb=0, Rc=14, op 0x1F: edge register indices
    run_instr("edge", 32'hFF870000, 0, 1'b0, 16'h0001, 16'h4000, 16'h8000, 5'h1F, 1'b0);

    // Reset mid-op in T4
    ir_data = 32'h489A8000;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("rst_at_t4_op", {27'd0, alu_op}, 32'h09);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk_state("rst_mid", 14'h0, 16'h0, 16'h0, 5'h0, 1'b0, 1'b0);
    run_instr("after_rst", 32'h489A8000, 0, 1'b0, 16'h0008, 16'h0020, 16'h0002, 5'h09, 1'b0);

    // start pulsed in T2 and T5 must be ignored; back-to-back start right after done
    run_instr("noise", 32'h489A8000, 0, 1'b0, 16'h0008, 16'h0020, 16'h0002, 5'h09, 1'b1);
    run_instr("b2b", 32'h79200000, 0, 1'b1, 16'h0004, 16'h0010, 16'h0000, 5'h0F, 1'b0);

`ifdef ALU_SEQ_STEP_EN
    begin
      int busy_cyc, d0, t0_cyc;
      busy_cyc = 0;
      t0_cyc   = 0;
      d0       = done_cnt;
      step     = 1'b0;
      ir_data  = 32'h489A8000;
      start    = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 30; c++) begin
        if (busy) busy_cyc++;
        if (pc_out) t0_cyc++;
        step = (c % 3 == 2);
        tick();
      end
      step = 1'b1;
      chk("step_busy_cycles", busy_cyc, 32'd18);
      chk("step_t0_cycles", t0_cyc, 32'd3);
      chk("step_ndone", done_cnt - d0, 32'd1);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_rr_sequencer.md
Name: alu_rr_sequencer

Overview:
- Parametrised control sequencer for register-register ALU instructions on the Mini SRC datapath.
- Runs the fetch/execute control steps T0..T6 and drives the one-hot register selects, bus-out strobes, ALU opcode and load enables that were previously sequenced by hand.
- Extends the fixed single-instruction flow with generic opcode/field decode, a memory-ready wait in fetch, and an extra HI/LO write-back step for mul/div.

Parameters:
DATA_WIDTH, 32, width of the IR value.
OPCODE_WIDTH, 5, opcode field width, located at ir_data[DATA_WIDTH-1 -: OPCODE_WIDTH].
REG_SEL_WIDTH, 4, width of each of the Ra/Rb/Rc fields, packed directly below the opcode in that order.
NUM_REGS, 16, number of general registers; width of the one-hot selects; must equal 2**REG_SEL_WIDTH.
MUL_OPCODE, 5'h0F, opcode that takes the two-result (LO/HI) path.
DIV_OPCODE, 5'h10, second opcode that takes the two-result path.

Ports:
clk  in  1  system clock, rising edge.
clr  in  1  synchronous active-high reset.
start  in  1  begin one instruction; sampled only in IDLE.
mem_ready  in  1  memory read data valid; sampled in T1.
ir_data  in  DATA_WIDTH  current IR contents.
pc_out, mar_in, inc_pc, z_in, zlow_out, zhigh_out, pc_in, read, mdr_in, mdr_out, ir_in, y_in, lo_in, hi_in  out  1 each  datapath strobes.
reg_out_sel  out  NUM_REGS  one-hot general-register bus driver.
reg_in_sel  out  NUM_REGS  one-hot general-register load enable.
alu_op  out  OPCODE_WIDTH  ALU operation select.
busy  out  1  high from T0 through the final step.
done  out  1  one-cycle pulse during the final step.

Behaviour:
- Interface: one clock, clk. Reset clr is synchronous and active-high.
- Reset: on a clk edge with clr=1, state becomes IDLE and all outputs are 0. clr overrides every other input and applies in any state, including mid-instruction.
- All outputs are Moore decodes of the state register plus the latched fields. All outputs are 0 in IDLE.
- IDLE -> T0 when start=1. start is ignored in every other state; there is no queuing.
- T0: pc_out, mar_in, inc_pc, z_in. Next state T1.
- T1: zlow_out, pc_in, read, mdr_in.
  - Stays in T1 while mem_ready=0; all four strobes are held for the whole wait.
  - T1 -> T2 on the first edge where mem_ready=1.
- T2: mdr_out, ir_in. Next state T3.
- T3: Ra, Rb, Rc and opcode are decoded combinationally from ir_data, which is valid because IR loaded on the T2->T3 edge.
  - Normal op: reg_out_sel = onehot(Rb), y_in.
  - Mul/div: reg_out_sel = onehot(Ra), y_in.
  - Fields and opcode are captured into internal registers on the edge leaving T3; T4..T6 use only the captured copies.
- T4: z_in; alu_op = captured opcode (alu_op is 0 in every other state).
  - Normal op: reg_out_sel = onehot(Rc).
  - Mul/div: reg_out_sel = onehot(Rb).
- T5:
  - Normal op: zlow_out, reg_in_sel = onehot(Ra), done=1. Next state IDLE.
  - Mul/div: zlow_out, lo_in. Next state T6.
- T6 (mul/div only): zhigh_out, hi_in, done=1. Next state IDLE.
- Instruction latency from start to the done cycle: 6 cycles (normal) or 7 cycles (mul/div), plus any mem_ready wait cycles.
- A new start is accepted in IDLE on the cycle after done.
- reg_out_sel and reg_in_sel are never both nonzero in the same cycle. At most one bus driver (pc_out, zlow_out, zhigh_out, mdr_out, reg_out_sel) is active per cycle.
- Opcodes are not validated; any value other than MUL_OPCODE or DIV_OPCODE takes the normal path.

Optional Feature:
- Macro: ALU_SEQ_STEP_EN.
- When defined:
  - Adds input port step (1 bit).
  - Every transition out of T0..T6 additionally requires step=1 on that edge.
  - The IDLE->T0 transition does not require step.
  - The T1 transition requires both step=1 and mem_ready=1.
  - Outputs hold their current state's values while waiting.
  - done pulses for exactly the one cycle on which the final step is released.
- When undefined: the port is absent and the block free-runs as described above.

Test Plan:
- Sequence check:
  - Stimulus: clr, then start=1 with mem_ready=1; ir_data=32'h489A8000 loaded at T2.
  - Response: T3 reg_out_sel=16'h0008 with y_in; T4 reg_out_sel=16'h0020, alu_op=5'h09, z_in; T5 zlow_out, reg_in_sel=16'h0002, done=1.
  - Total: 6 cycles, then IDLE.
- Mul/div path:
  - Stimulus: ir_data=32'h79200000 (mul, Ra=2, Rb=4).
  - Response: T3 reg_out_sel=16'h0004; T4 reg_out_sel=16'h0010, alu_op=5'h0F; T5 lo_in; T6 zhigh_out, hi_in, done.
  - Total: 7 cycles.
- Memory wait:
  - Stimulus: mem_ready=0 for 3 cycles after entering T1.
  - Response: read and mdr_in held for 4 cycles, T2 entered on the 5th, done 3 cycles later than the no-wait case.
- Reset mid-op:
  - Stimulus: clr=1 during T4.
  - Response: next cycle IDLE, all outputs 0. A following start runs a full instruction normally.
- Busy ignore:
  - Stimulus: start pulsed during T2 and T5.
  - Response: no restart, single done. start=1 in the cycle after done begins a new T0.
- Step mode (ALU_SEQ_STEP_EN):
  - Stimulus: step pulsed every 3rd cycle.
  - Response: each state persists until its step edge; the done pulse is exactly 1 cycle.
